// File: rtl/alu_control_unit_pkg.sv
// Shared opcode codes and decode helpers for the ALU control unit.
// ALU opcodes match the selector codes the combinational ALU expects;
// LDI/JMP/JZ/HLT occupy codes the ALU never sees.
package alu_control_unit_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_NAND = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_CMP  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_LDI  = 5'd24;
    localparam logic [4:0] OP_JMP  = 5'd25;
    localparam logic [4:0] OP_JZ   = 5'd26;
    localparam logic [4:0] OP_HLT  = 5'd31;

    // True for opcodes that go through the ALU (DECODE -> EXECUTE -> WRITEBACK).
    function automatic logic is_alu_op(input logic [4:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
            OP_NAND, OP_OR, OP_XOR, OP_CMP, OP_NOT: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // Only arithmetic ops that can overflow update the carry flag.
    function automatic logic updates_carry(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_control_unit_reg_file_8x8.sv
// 8x8 register file: one synchronous write port, two asynchronous
// operand read ports and an asynchronous debug read port.
module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // Clear every register on reset; otherwise write one register when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle control unit driving the combinational ALU: fetches 16-bit
// instructions over a req/ack port, decodes them, registers the ALU
// operands/selector, samples the result and writes it back.
module alu_control_unit
    import alu_control_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [15:0]              imem_rdata,
    output logic signed [DATA_W-1:0] alu_in1,
    output logic signed [DATA_W-1:0] alu_in2,
    output logic [4:0]               alu_sel,
    input  logic signed [DATA_W-1:0] alu_out,
    input  logic                     alu_carry,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     div_err,
    output logic                     halted,
    output logic [PC_W-1:0]          pc,
    input  logic [2:0]               dbg_sel,
    output logic [DATA_W-1:0]        dbg_data
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [15:0]              instr;
    logic signed [DATA_W-1:0] result;
    logic                     carry;

    logic [4:0] opcode;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm8;

    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic              rf_we;
    logic              fetch_done;

    assign opcode = instr[15:11];
    assign rd     = instr[10:8];
    assign rs1    = instr[7:5];
    assign rs2    = instr[4:2];
    assign imm8   = instr[7:0];

    assign imem_addr  = pc;
    assign halted     = (state == S_HALT);
    assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
    assign rf_we      = (state == S_WRITEBACK);

    reg_file_8x8 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (result),
        .raddr1   (rs1),
        .rdata1   (rf_rdata1),
        .raddr2   (rs2),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; LDI skips EXECUTE, control-flow and NOP return straight to FETCH.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (fetch_done) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu_op(opcode)) begin
                    state_nxt = S_EXECUTE;
                end else if (opcode == OP_LDI) begin
                    state_nxt = S_WRITEBACK;
                end else if (opcode == OP_HLT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_FETCH;
        endcase
    end

    // Fetch handshake, operand/result registers, flags and program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req <= 1'b0;
            instr    <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_sel  <= '0;
            result   <= '0;
            carry    <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            div_err  <= 1'b0;
            pc       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Request is raised one cycle into FETCH and held until acked.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_alu_op(opcode)) begin
                        alu_in1 <= rf_rdata1;
                        alu_in2 <= (opcode == OP_NOT) ? '0 : rf_rdata2;
                        alu_sel <= opcode;
                    end else begin
                        case (opcode)
                            OP_LDI:  result <= DATA_W'(imm8);
                            OP_JMP:  pc     <= PC_W'(imm8);
                            OP_JZ:   pc     <= flag_z ? PC_W'(imm8) : pc + PC_W'(1);
                            OP_HLT:  pc     <= pc;
                            default: pc     <= pc + PC_W'(1);
                        endcase
                    end
                end
                S_EXECUTE: begin
                    // Divide by zero yields 0 and latches the sticky error.
                    if ((alu_sel == OP_DIV) && (alu_in2 == '0)) begin
                        result  <= '0;
                        div_err <= 1'b1;
                    end else begin
                        result <= alu_out;
                    end
                    carry <= alu_carry;
                end
                S_WRITEBACK: begin
                    if (opcode != OP_LDI) begin
                        flag_z <= (result == '0);
                        if (updates_carry(opcode)) begin
                            flag_c <= carry;
                        end
                    end
                    pc <= pc + PC_W'(1);
                end
                default: begin
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a behavioural instruction
// memory and a behavioural combinational ALU.
module tb_alu_control_unit;
    import alu_control_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [7:0]        imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic signed [7:0] alu_in1, alu_in2;
    logic [4:0]        alu_sel;
    logic signed [7:0] alu_out;
    logic              alu_carry;
    logic              flag_z, flag_c, div_err, halted;
    logic [7:0]        pc;
    logic [2:0]        dbg_sel = 3'd0;
    logic [7:0]        dbg_data;

    logic [15:0] imem [256];
    logic        ack_gate = 1'b1;

    int checks = 0;
    int errors = 0;

    alu_control_unit #(.DATA_W(8), .PC_W(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .div_err    (div_err),
        .halted     (halted),
        .pc         (pc),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Instruction memory responds in the same cycle whenever the gate is open.
    assign imem_ack   = imem_req & ack_gate;
    assign imem_rdata = imem[imem_addr];

    // Reference combinational ALU.
    always_comb begin
        logic [7:0]  u1, u2;
        logic [15:0] prod;
        u1 = alu_in1;
        u2 = alu_in2;
        prod = u1 * u2;
        alu_out = '0;
        alu_carry = 1'b0;
        case (alu_sel)
            OP_ADD:  {alu_carry, alu_out} = {1'b0, u1} + {1'b0, u2};
            OP_SUB:  alu_out = u1 - u2;
            OP_MUL:  begin alu_out = prod[7:0]; alu_carry = |prod[15:8]; end
            OP_DIV:  alu_out = (u2 == 8'd0) ? 8'hFF : u1 / u2;
            OP_AND:  alu_out = u1 & u2;
            OP_NAND: alu_out = ~(u1 & u2);
            OP_OR:   alu_out = u1 | u2;
            OP_XOR:  alu_out = u1 ^ u2;
            OP_CMP:  alu_out = (alu_in1 > alu_in2) ? 8'sd1 : (alu_in1 < alu_in2) ? -8'sd1 : 8'sd0;
            OP_NOT:  alu_out = ~u1;
            default: alu_out = '0;
        endcase
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input int rd, input int rs1, input int rs2);
        return {op, 3'(rd), 3'(rs1), 3'(rs2), 2'b00};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input int rd, input logic [7:0] imm);
        return {op, 3'(rd), imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [7:0] exp);
        dbg_sel = 3'(idx);
        #1;
        check(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = enc_i(OP_HLT, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {15'd0, halted}, 16'd1);
    endtask

    // Returns the address of the next accepted fetch; leaves time one cycle after the ack edge.
    task automatic next_fetch(input string tag, output logic [7:0] a);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        a = 8'hxx;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (imem_req && imem_ack) begin
                a = imem_addr;
                got = 1'b1;
            end
        end
        if (!got) check({tag, "_timeout"}, 16'd0, 16'd1);
        @(negedge clk);
    endtask

    logic [7:0] fa;

    initial begin
        // ---- Reset state and basic add ----
        clear_mem();
        imem[0] = enc_i(OP_LDI, 1, 8'd5);
        imem[1] = enc_i(OP_LDI, 2, 8'd3);
        imem[2] = enc(OP_ADD, 3, 1, 2);
        imem[3] = enc_i(OP_HLT, 0, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", {8'h00, pc}, 16'h0000);
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_flags", {12'd0, flag_z, flag_c, div_err, halted}, 16'd0);
        check("rst_alu", {alu_in1, 3'b000, alu_sel}, 16'd0);
        check("rst_alu_in2", {8'h00, alu_in2}, 16'd0);
        chk_reg("rst_r3", 3, 8'd0);
        rst = 1'b0;
        run_until_halt("t1_halt", 200);
        chk_reg("t1_r3", 3, 8'd8);
        check("t1_flag_z", {15'd0, flag_z}, 16'd0);
        check("t1_pc", {8'h00, pc}, 16'h0003);
        repeat (4) @(negedge clk);
        check("t1_frozen", {7'd0, imem_req, pc}, 16'h0003);

        // ---- Zero flag and taken JZ ----
        clear_mem();
        imem[0] = enc_i(OP_LDI, 1, 8'd7);
        imem[1] = enc(OP_SUB, 2, 1, 1);
        imem[2] = enc_i(OP_JZ, 0, 8'h10);
        imem[16] = enc_i(OP_HLT, 0, 8'h00);
        do_reset();
        next_fetch("t2_f0", fa);
        next_fetch("t2_f1", fa);
        next_fetch("t2_f2", fa);
        check("t2_jz_addr", {8'h00, fa}, 16'h0002);
        chk_reg("t2_r2", 2, 8'd0);
        check("t2_flag_z", {15'd0, flag_z}, 16'd1);
        next_fetch("t2_f3", fa);
        check("t2_jz_target", {8'h00, fa}, 16'h0010);
        run_until_halt("t2_halt", 100);
        check("t2_pc", {8'h00, pc}, 16'h0010);

        // ---- Divide by zero, NOP, CMP, carry ----
        clear_mem();
        imem[0] = enc_i(OP_LDI, 2, 8'h55);
        imem[1] = enc_i(OP_LDI, 1, 8'd9);
        imem[2] = enc(OP_DIV, 2, 1, 0);
        imem[3] = enc_i(OP_LDI, 3, 8'd4);
        imem[4] = enc(5'd12, 1, 3, 3);
        imem[5] = enc(OP_CMP, 5, 3, 1);
        imem[6] = enc_i(OP_LDI, 6, 8'hF0);
        imem[7] = enc(OP_ADD, 7, 6, 6);
        imem[8] = enc(OP_SUB, 4, 3, 3);
        imem[9] = enc_i(OP_HLT, 0, 8'h00);
        do_reset();
        run_until_halt("t3_halt", 400);
        chk_reg("t3_r2_div0", 2, 8'd0);
        check("t3_div_err", {15'd0, div_err}, 16'd1);
        chk_reg("t3_r1_nop", 1, 8'd9);
        chk_reg("t3_r5_cmp", 5, 8'hFF);
        chk_reg("t3_r7_add", 7, 8'hE0);
        chk_reg("t3_r4_sub", 4, 8'd0);
        check("t3_flags_zc", {14'd0, flag_z, flag_c}, 16'd3);
        check("t3_pc", {8'h00, pc}, 16'h0009);

        // ---- Fetch stall with ack held low ----
        clear_mem();
        imem[0] = enc_i(OP_LDI, 1, 8'd1);
        imem[1] = enc_i(OP_HLT, 0, 8'h00);
        ack_gate = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall", {7'd0, imem_req, imem_addr}, 16'h0100);
        end
        chk_reg("t4_r1_held", 1, 8'd0);
        ack_gate = 1'b1;
        run_until_halt("t4_halt", 100);
        chk_reg("t4_r1", 1, 8'd1);
        check("t4_pc", {8'h00, pc}, 16'h0001);

        // ---- Jump to top of memory and wrap ----
        clear_mem();
        imem[0] = enc_i(OP_JMP, 0, 8'hFF);
        imem[255] = enc_i(OP_LDI, 4, 8'd1);
        do_reset();
        next_fetch("t5_f0", fa);
        check("t5_first", {8'h00, fa}, 16'h0000);
        next_fetch("t5_f1", fa);
        check("t5_jmp", {8'h00, fa}, 16'h00FF);
        next_fetch("t5_f2", fa);
        check("t5_wrap", {8'h00, fa}, 16'h0000);
        chk_reg("t5_r4", 4, 8'd1);

        // ---- Reset during EXECUTE of ADD ----
        clear_mem();
        imem[0] = enc_i(OP_LDI, 1, 8'd5);
        imem[1] = enc_i(OP_LDI, 2, 8'd3);
        imem[2] = enc(OP_ADD, 3, 1, 2);
        do_reset();
        next_fetch("t6_f0", fa);
        next_fetch("t6_f1", fa);
        next_fetch("t6_f2", fa);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_pc", {8'h00, pc}, 16'h0000);
        check("t6_req", {15'd0, imem_req}, 16'd0);
        chk_reg("t6_r3", 3, 8'd0);
        chk_reg("t6_r1", 1, 8'd0);
        next_fetch("t6_refetch", fa);
        check("t6_refetch_addr", {8'h00, fa}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
